// File: rtl/div_iter.sv
// rtl/div_iter.sv - radix-2 restoring 32-bit divider, signed/unsigned; DIV_FASTPATH_EN shortcuts special cases
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         enable,
    input  logic         is_signed,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         busy,
    output logic         completed,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);
    localparam int CW = $clog2(W);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem, quo, dvs, s_raw;
    logic          sign_q, sign_r, sp_dz, sp_ovf, sp_one;

    logic [W-1:0]  abs_s, abs_t;
    logic          dz, ovf, one;
    logic [W:0]    shifted;
    logic [W-1:0]  sub;
    logic          ge;

    always_comb begin
        abs_s   = (is_signed && s[W-1]) ? -s : s;
        abs_t   = (is_signed && t[W-1]) ? -t : t;
        dz      = (t == '0);
        ovf     = is_signed && (s == MIN_NEG) && (t == '1);
        one     = (t == ONE) && (!is_signed || !s[W-1]);
        shifted = {rem, quo[W-1]};
        ge      = (shifted >= {1'b0, dvs});
        // The true difference always fits W bits when ge holds, so modular W-bit subtraction suffices.
        sub     = shifted[W-1:0] - dvs;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            s_raw     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            sp_dz     <= 1'b0;
            sp_ovf    <= 1'b0;
            sp_one    <= 1'b0;
            busy      <= 1'b0;
            completed <= 1'b0;
            q         <= '0;
            r         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    completed <= 1'b0;
                    if (enable) begin
                        quo    <= abs_s;
                        dvs    <= abs_t;
                        s_raw  <= s;
                        sign_q <= is_signed & (s[W-1] ^ t[W-1]);
                        sign_r <= is_signed & s[W-1];
                        sp_dz  <= dz;
                        sp_ovf <= ovf;
                        sp_one <= one;
                        rem    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
`ifdef DIV_FASTPATH_EN
                        state  <= (dz || ovf || one) ? FIX : CALC;
`else
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem <= ge ? sub : shifted[W-1:0];
                    quo <= {quo[W-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1))
                        state <= FIX;
                end
                FIX: begin
                    // Special cases bypass sign correction: their results are fixed at launch.
                    if (sp_dz) begin
                        q <= '1;
                        r <= s_raw;
                    end else if (sp_ovf) begin
                        q <= MIN_NEG;
                        r <= '0;
                    end else if (sp_one) begin
                        q <= s_raw;
                        r <= '0;
                    end else begin
                        q <= sign_q ? -quo : quo;
                        r <= sign_r ? -rem : rem;
                    end
                    completed <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Sequential 32-bit integer divider; the inverse companion of the pipelined multiplier in the same arithmetic unit.
- Computes quotient and remainder, signed or unsigned, using a radix-2 restoring algorithm at one bit per cycle.
- Uses the same enable/completed handshake as the multiplier, so the execute stage drives both the same way.
- Not pipelined: one division in flight at a time; busy tells the issuing stage to hold.

Parameters:
- W, 32, operand width; the quotient and remainder are also W bits.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- enable  in  1  start request; sampled only while the block is idle.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned operands.
- s  in  W  dividend.
- t  in  W  divisor.
- busy  out  1  high while a division is in progress.
- completed  out  1  one-cycle pulse; q and r are valid while it is high.
- q  out  W  quotient.
- r  out  W  remainder.

Behaviour:
- Reset (rstn low, takes effect immediately without waiting for a clock edge):
  - state returns to IDLE;
  - busy=0, completed=0, q=0, r=0;
  - the iteration counter and all internal operand registers clear.
  - Reset in the middle of a division aborts it; no completed pulse follows.
- States: IDLE, CALC, FIX.
- IDLE:
  - Holds q and r at their last values.
  - On an edge where enable=1, the block latches s, t and is_signed.
  - It forms |s| and |t|; absolute values are taken only when is_signed=1 and the operand's MSB is 1.
  - It records sign_q = is_signed & (s[31]^t[31]) and sign_r = is_signed & s[31].
  - It clears the partial remainder and counter, then goes to CALC with busy=1.
- CALC, one iteration per edge, 32 edges with counter 0..31:
  - shift the {remainder, dividend} register left by 1;
  - trial-subtract |t| from the upper W+1 bits;
  - if the result is non-negative, keep the difference and set quotient bit 1; otherwise restore and set 0.
  - After counter 31, go to FIX.
- FIX, one edge:
  - q = sign_q ? -Q : Q and r = sign_r ? -R : R, with 32-bit wrap;
  - completed=1 for exactly this one cycle, busy=0, then return to IDLE.
- Latency: enable sampled at edge N gives completed=1 in the cycle after edge N+33; that is 34 edges including the launch edge.
- Back-to-back: enable=1 during the completed cycle is accepted at the next edge (the block is in IDLE).
- enable while busy=1 is ignored; the operation in flight is unaffected and no request is queued.
- The block assumes the s/t/is_signed inputs may change freely after the launch edge.
- Divide by zero (t=0), both modes: q=0xFFFFFFFF, r=s, with no sign correction applied.
- Signed overflow (s=0x80000000, t=0xFFFFFFFF, is_signed=1): q=0x80000000, r=0.
- Special cases are detected at launch and their results are forced in FIX.
- Remainder sign follows the dividend; the quotient truncates toward zero.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- Defined:
  - divide-by-zero and signed overflow skip CALC; IDLE goes straight to FIX;
  - completed=1 in the cycle after edge N+1 (latency 2).
  - Divisions with t=1 (unsigned, or signed positive dividend) also take the fast path: q=s, r=0.
- Undefined:
  - every operation takes the full 34-edge latency;
  - the result values are identical to the defined case.

Test Plan:
- Unsigned s=100, t=7 -> completed pulses exactly 34 edges after launch; q=14, r=2; busy high for 33 cycles.
- Signed s=0xFFFFFFF9 (-7), t=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also check s=7, t=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
- Divide by zero, signed s=0xFFFFFFFB, t=0 -> q=0xFFFFFFFF, r=0xFFFFFFFB.
  - Latency is 34 edges without DIV_FASTPATH_EN and 2 edges with it.
- Signed overflow s=0x80000000, t=0xFFFFFFFF -> q=0x80000000, r=0. The same operands unsigned give q=0, r=0x80000000.
- Launch s=1000, t=3, then pulse enable with s=9, t=9 at cycle 5 -> the second request is ignored; q=333, r=1.
  - Next, enable during the completed cycle with s=9, t=9 -> second result q=1, r=0.
- Launch, then drop rstn low at cycle 10 between clock edges -> busy/completed/q/r are 0 immediately.
  - No completed pulse appears over the next 40 cycles.
  - A new launch with s=50, t=5 gives q=10, r=0.
